// File: rtl/cu_pkg.sv
// Shared encodings for the control-unit slice: sequencer states, instruction
// classes and the datapath control-word field map.
package cu_pkg;

  typedef enum logic [3:0] {
    ST_FETCH = 4'b0000,
    ST_EX0   = 4'b0001,
    ST_EX1   = 4'b0010,
    ST_EX2   = 4'b0011
  } state_e;

  typedef enum logic [1:0] {
    CLS_ALU    = 2'd0,
    CLS_BRANCH = 2'd1,
    CLS_MEM    = 2'd2,
    CLS_IMM    = 2'd3
  } class_e;

  // Control-word field offsets (LSB of each field).
  localparam int CW_PC_FS       = 0;
  localparam int CW_PC_SEL      = 2;
  localparam int CW_DATA_TRI    = 3;
  localparam int CW_ADD_TRI     = 5;
  localparam int CW_SIZE        = 6;
  localparam int CW_STATUS_LOAD = 8;
  localparam int CW_IR_LOAD     = 9;
  localparam int CW_MEM_WE      = 10;
  localparam int CW_B_SEL       = 11;
  localparam int CW_MEM_CS      = 12;
  localparam int CW_C0          = 14;
  localparam int CW_W_REG       = 15;
  localparam int CW_DA          = 16;
  localparam int CW_SB          = 21;
  localparam int CW_SA          = 26;
  localparam int CW_FS          = 31;
  localparam int CW_MAP_W       = 36;

  // Fetch word: memory selected, address from PC.
  localparam logic [CW_MAP_W-1:0] FETCH_CW =
    (36'd1 << CW_MEM_CS) | (36'd1 << CW_ADD_TRI) | (36'd1 << CW_PC_SEL);

  // Added once the fetch completes: load IR and advance PC.
  localparam logic [CW_MAP_W-1:0] FETCH_READY_CW =
    (36'd1 << CW_IR_LOAD) | (36'd1 << CW_PC_FS);

  // Fields suppressed while a memory access stalls: no PC update, no writeback.
  localparam logic [CW_MAP_W-1:0] STALL_CLR_CW =
    (36'd3 << CW_PC_FS) | (36'd1 << CW_W_REG) | (36'd1 << CW_STATUS_LOAD);

endpackage

// File: rtl/cu_class_decode.sv
// Instruction class decode from IR[28:25]; earlier rules take priority.
module cu_class_decode
  import cu_pkg::*;
(
  input  logic [3:0] i_op,
  output logic [1:0] o_class
);

  // NOTE: a priority if/else chain ending in an unconditional else assigns
  // o_class on every path, so no latch is inferred.
  always_comb begin
    if (i_op[3:1] == 3'b101)
      o_class = CLS_BRANCH;
    else if (i_op[3:1] == 3'b100)
      o_class = CLS_IMM;
    else if (i_op[2] && !i_op[0])
      o_class = CLS_MEM;
    else
      o_class = CLS_ALU;
  end

endmodule

// File: rtl/cu_sequencer.sv
// Control-unit sequencer: owns the FETCH/EX state, muxes sub-unit control words
// and next-state proposals, and bounds execute length with a watchdog.
module cu_sequencer
  import cu_pkg::*;
#(
  parameter int CUL    = 36,
  parameter int MAX_EX = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [31:0]  IR,
  input  logic         mem_ready,
  input  logic [3:0]   alu_status,
  input  logic [3:0]   ns_branch,
  input  logic [3:0]   ns_alu,
  input  logic [3:0]   ns_mem,
  input  logic [3:0]   ns_imm,
  input  logic [CUL:0] cw_branch,
  input  logic [CUL:0] cw_alu,
  input  logic [CUL:0] cw_mem,
  input  logic [CUL:0] cw_imm,
  output logic [3:0]   state,
  output logic [CUL:0] controlWord,
  output logic [3:0]   status,
  output logic [15:0]  retired,
  output logic         fault
);

  localparam int                CW_W    = CUL + 1;
  localparam int                CNT_W   = $clog2(MAX_EX) + 1;
  localparam logic [CNT_W-1:0]  WD_LAST = CNT_W'(MAX_EX - 1);

  state_e           r_state;
  logic [3:0]       r_status;
  logic [15:0]      r_retired;
  logic             r_fault;
  logic [CNT_W-1:0] r_ex_cnt;

  logic [1:0]       w_class_raw;
  class_e           w_class;
  logic [CUL:0]     w_cw_sel;
  logic [3:0]       w_ns_sel;
  logic             w_stall;
  logic [CUL:0]     w_cw;
  logic             w_unused_ir;

  assign w_unused_ir = ^{IR[31:29], IR[24:0]};

  cu_class_decode u_class_decode (
    .i_op    (IR[28:25]),
    .o_class (w_class_raw)
  );

  assign w_class = class_e'(w_class_raw);

  always_comb begin
    w_cw_sel = cw_alu;
    w_ns_sel = ns_alu;
    case (w_class)
      CLS_BRANCH: begin w_cw_sel = cw_branch; w_ns_sel = ns_branch; end
      CLS_MEM:    begin w_cw_sel = cw_mem;    w_ns_sel = ns_mem;    end
      CLS_IMM:    begin w_cw_sel = cw_imm;    w_ns_sel = ns_imm;    end
      default:    begin w_cw_sel = cw_alu;    w_ns_sel = ns_alu;    end
    endcase
  end

  assign w_stall = (r_state != ST_FETCH) && (w_class == CLS_MEM) && !mem_ready;

  always_comb begin
    w_cw = w_cw_sel;
    if (r_state == ST_FETCH) begin
      w_cw = CW_W'(FETCH_CW);
      if (mem_ready) w_cw = w_cw | CW_W'(FETCH_READY_CW);
    end else if (w_stall) begin
      w_cw = cw_mem & ~CW_W'(STALL_CLR_CW);
    end
  end

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_FETCH;
      r_status  <= '0;
      r_retired <= '0;
      r_fault   <= 1'b0;
      r_ex_cnt  <= '0;
    end else begin
      if (w_cw[CW_STATUS_LOAD]) r_status <= alu_status;
      case (r_state)
        ST_FETCH: begin
          if (mem_ready) begin
            r_state  <= ST_EX0;
            r_ex_cnt <= '0;
          end
        end
        default: begin
          if (!w_stall) begin
            if (w_ns_sel > ST_EX2) begin
              r_state <= ST_FETCH;
              r_fault <= 1'b1;
            end else if (w_ns_sel == ST_FETCH) begin
              r_state   <= ST_FETCH;
              r_retired <= r_retired + 16'd1;
            end else if (r_ex_cnt == WD_LAST) begin
              // Execute budget exhausted without completing: abort.
              r_state <= ST_FETCH;
              r_fault <= 1'b1;
            end else begin
              r_state  <= state_e'(w_ns_sel);
              r_ex_cnt <= r_ex_cnt + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign state       = r_state;
  assign controlWord = w_cw;
  assign status      = r_status;
  assign retired     = r_retired;
  assign fault       = r_fault;

endmodule
